// File: rtl/weight_fetch_scheduler.sv
// weight_fetch_scheduler: streams one COMPUTE job's kernel weights from a dual-port BRAM to the MAC array.
// Ports: clk, rst_n (async active-low); axi_control_0 instruction, axi_control_1 pool/base,
// axi_control_2 kernel one-hot/abort/group count; bram_address_A/B + bram_A_en/B_en issue reads,
// weight_from_bram_A/B return data one cycle later; weight_out/weight_valid/weight_ready stream words
// to the consumer; done pulses at job end; axi_control_3 reports busy/done/error/delivered count.
module weight_fetch_scheduler #(
    parameter int MAC_NUM              = 256,
    parameter int WEIGHT_WIDTH         = 1280,
    parameter int BRAM_ADDRESS_WIDTH   = 12,
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int INST_COMPUTE         = 87
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] axi_control_0,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] axi_control_1,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] axi_control_2,
    output logic [BRAM_ADDRESS_WIDTH-1:0]   bram_address_A,
    output logic [BRAM_ADDRESS_WIDTH-1:0]   bram_address_B,
    output logic                            bram_A_en,
    output logic                            bram_B_en,
    input  logic [WEIGHT_WIDTH-1:0]         weight_from_bram_A,
    input  logic [WEIGHT_WIDTH-1:0]         weight_from_bram_B,
    output logic [WEIGHT_WIDTH-1:0]         weight_out,
    output logic                            weight_valid,
    input  logic                            weight_ready,
    output logic                            done,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] axi_control_3
);
    // Word count N = K*G peaks at 5 * MAC_NUM (G=0 encodes MAC_NUM groups).
    localparam int CNT_W = $clog2(5 * MAC_NUM + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                          state_q, state_d;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] ctrl0_q;
    logic                            arm_q;
    logic [BRAM_ADDRESS_WIDTH-1:0]   base_q, addr_a_q, addr_b_q, addr;
    logic [CNT_W-1:0]                n_q, i_q, cnt_q, k_val, g_val, n_calc;
    logic                            err_q, done_st_q;
    logic [WEIGHT_WIDTH-1:0]         buf_q [2];
    logic                            rd_q, wr_q, inf_q, inf_b_q;
    logic [1:0]                      occ_q;
    logic [2:0]                      credit;
    logic                            is_inst, start, abort, kvalid, busy, pop, push, issue;
    logic [4:0]                      kern;
    logic                            unused_ok;

    assign unused_ok = ^{axi_control_1[31:28], axi_control_1[15:1], axi_control_2[31:16],
                         axi_control_2[7], axi_control_2[5]};

    // arm_q blocks a start until axi_control_0 has been seen away from the opcode since reset,
    // so holding the opcode through reset release cannot launch a job.
    assign is_inst = axi_control_0 == C_S_AXIS_TDATA_WIDTH'(INST_COMPUTE);
    assign start   = state_q == IDLE && arm_q && is_inst && ctrl0_q != C_S_AXIS_TDATA_WIDTH'(INST_COMPUTE);
    assign busy    = state_q == FETCH || state_q == DRAIN;
    assign abort   = busy && axi_control_2[6];

    assign kern   = axi_control_2[4:0];
    assign kvalid = $onehot(kern);
    assign k_val  = CNT_W'(kern[0] ? 1 : kern[1] ? 2 : kern[2] ? 3 : kern[3] ? 4 : 5);
    assign g_val  = axi_control_2[15:8] == 8'd0 ? CNT_W'(MAC_NUM) : CNT_W'(axi_control_2[15:8]);
    assign n_calc = k_val * g_val;

    assign weight_valid = occ_q != 2'd0;
    assign weight_out   = buf_q[rd_q];
    assign pop          = weight_valid && weight_ready;
    assign push         = inf_q && !abort;

    // Credit the word leaving this cycle so a steady ready stream sees no bubbles;
    // buffered + in-flight never exceeds two.
    assign credit = 3'(occ_q) + 3'(inf_q) - 3'(pop);
    assign issue  = state_q == FETCH && !abort && credit < 3'd2;
    assign addr   = base_q + BRAM_ADDRESS_WIDTH'(i_q);

    assign bram_A_en      = issue && !i_q[0];
    assign bram_B_en      = issue && i_q[0];
    assign bram_address_A = bram_A_en ? addr : addr_a_q;
    assign bram_address_B = bram_B_en ? addr : addr_b_q;

    assign done          = state_q == DONE;
    assign axi_control_3 = C_S_AXIS_TDATA_WIDTH'({cnt_q, 13'b0, err_q, done_st_q, busy});

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (axi_control_1[0] || !kvalid) ? DONE : FETCH;
            FETCH:   if (abort) state_d = DONE;
                     else if (issue && i_q == n_q - CNT_W'(1)) state_d = DRAIN;
            DRAIN:   if (abort || (pop && cnt_q + CNT_W'(1) == n_q)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ctrl0_q   <= '0;
            arm_q     <= 1'b0;
            base_q    <= '0;
            n_q       <= '0;
            i_q       <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            done_st_q <= 1'b0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl0_q <= axi_control_0;
            if (!is_inst) arm_q <= 1'b1;
            if (start) begin
                base_q    <= axi_control_1[27:16];
                n_q       <= n_calc;
                i_q       <= '0;
                cnt_q     <= '0;
                err_q     <= !axi_control_1[0] && !kvalid;
                done_st_q <= 1'b0;
            end
            if (pop) cnt_q <= cnt_q + CNT_W'(1);
            if (issue) i_q <= i_q + CNT_W'(1);
            if (state_d == DONE) done_st_q <= 1'b1;
            if (bram_A_en) addr_a_q <= addr;
            if (bram_B_en) addr_b_q <= addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            occ_q    <= 2'd0;
            inf_q    <= 1'b0;
            inf_b_q  <= 1'b0;
        end else begin
            inf_q <= issue;
            if (issue) inf_b_q <= i_q[0];
            if (abort) begin
                rd_q  <= 1'b0;
                wr_q  <= 1'b0;
                occ_q <= 2'd0;
            end else begin
                if (push) begin
                    buf_q[wr_q] <= inf_b_q ? weight_from_bram_B : weight_from_bram_A;
                    wr_q        <= ~wr_q;
                end
                if (pop) rd_q <= ~rd_q;
                occ_q <= occ_q + 2'(push) - 2'(pop);
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && occ_q == 2'd2));
endmodule

// File: tb/tb_weight_fetch_scheduler.sv
module tb_weight_fetch_scheduler;
    logic          clk = 0, rst_n = 0;
    logic [31:0]   ctrl0 = 0, ctrl1 = 0, ctrl2 = 0, ctrl3;
    logic [11:0]   addr_a, addr_b;
    logic          en_a, en_b, weight_valid, done;
    logic          weight_ready = 0;
    logic [1279:0] wa = '0, wb = '0, weight_out;

    weight_fetch_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .axi_control_0(ctrl0), .axi_control_1(ctrl1), .axi_control_2(ctrl2),
        .bram_address_A(addr_a), .bram_address_B(addr_b),
        .bram_A_en(en_a), .bram_B_en(en_b),
        .weight_from_bram_A(wa), .weight_from_bram_B(wb),
        .weight_out(weight_out), .weight_valid(weight_valid), .weight_ready(weight_ready),
        .done(done), .axi_control_3(ctrl3)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    int en_job = 0, x_job = 0, done_cnt = 0, done_cyc = -1, first_en = -1, first_x = -1, last_x = -1;
    bit chk_occ = 0;
    logic pv = 0, pr = 0;
    logic [1279:0] pw;
    logic [1279:0] exp_q [$];
    logic [12:0]   aq [$];

    function automatic logic [1279:0] pat(input logic p, input logic [11:0] a);
        logic [31:0] w;
        w = {p ? 4'hB : 4'hA, 4'h5, a, ~a};
        return {40{w}};
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (en_a) wa <= pat(1'b0, addr_a);
        if (en_b) wb <= pat(1'b1, addr_b);
    end

    // Scoreboard: reads and delivered words are checked against what each job queued at start.
    always @(negedge clk) begin
        if (!rst_n) pv = 0;
        else begin
            if (chk_occ) begin
                tests++;
                if (en_job - x_job > 2) begin
                    fails++;
                    $display("FAIL outstanding: got %0d want <=2", en_job - x_job);
                end
            end
            if (en_a || en_b) begin
                logic [13:0] got, expv;
                logic [12:0] e;
                got = {en_a, en_b, en_b ? addr_b : addr_a};
                tests++;
                if (aq.size() == 0) begin
                    fails++;
                    $display("FAIL read_issue: got %h want no read", got);
                end else begin
                    e = aq.pop_front();
                    expv = {~e[12], e[12], e[11:0]};
                    if (got !== expv) begin
                        fails++;
                        $display("FAIL read_addr: got %h want %h", got, expv);
                    end
                end
                if (first_en < 0) first_en = cyc;
                en_job++;
            end
            if (pv && !pr) begin
                tests++;
                if (!weight_valid || weight_out !== pw) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%0b %h want v=1 %h", weight_valid, weight_out[31:0], pw[31:0]);
                end
            end
            if (weight_valid && weight_ready) begin
                logic [1279:0] ew;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL word: got %h want no word", weight_out[31:0]);
                end else begin
                    ew = exp_q.pop_front();
                    if (weight_out !== ew) begin
                        fails++;
                        $display("FAIL word: got %h want %h", weight_out[31:0], ew[31:0]);
                    end
                end
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                x_job++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            pv = weight_valid;
            pr = weight_ready;
            pw = weight_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [11:0] base, input logic [4:0] kern, input logic [7:0] g,
                             input logic pool, output int s);
        int k, n;
        step();
        ctrl0 = 0;
        step();
        ctrl1 = {4'b0, base, 15'b0, pool};
        ctrl2 = {16'b0, g, 8'b0} | {27'b0, kern};
        en_job = 0; x_job = 0; first_en = -1; first_x = -1; last_x = -1;
        k = 0;
        for (int b = 0; b < 5; b++) if (kern[b]) k = b + 1;
        n = (!pool && $onehot(kern)) ? k * ((g == 0) ? 256 : int'(g)) : 0;
        for (int i = 0; i < n; i++) begin
            logic [11:0] a;
            a = base + 12'(i);
            exp_q.push_back(pat(i[0], a));
            aq.push_back({i[0], a});
        end
        ctrl0 = 87;
        s = cyc;
    endtask

    task automatic wait_done(input int d0);
        for (int c = 0; c < 400 && done_cnt == d0; c++) step();
        tests++;
        if (done_cnt == d0) begin
            fails++;
            $display("FAIL done_timeout: got no done want done pulse");
        end
    endtask

    task automatic test_reset();
        step(); step();
        tests++;
        if ({en_a, en_b, addr_a, addr_b} !== 26'd0) begin
            fails++;
            $display("FAIL reset_bram: got %h want 0", {en_a, en_b, addr_a, addr_b});
        end
        tests++;
        if (weight_out !== '0 || weight_valid !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_out: got v=%0b d=%0b w=%h want 0", weight_valid, done, weight_out[31:0]);
        end
        tests++;
        if (ctrl3 !== 32'd0) begin
            fails++;
            $display("FAIL reset_status: got %h want 0", ctrl3);
        end
        rst_n = 1;
    endtask

    task automatic test_basic();
        int s, d0;
        weight_ready = 1;
        d0 = done_cnt;
        start_job(12'h010, 5'b00100, 8'd2, 1'b0, s);
        wait_done(d0);
        step(); step();
        tests++;
        if (x_job != 6) begin fails++; $display("FAIL basic_count: got %0d want 6", x_job); end
        tests++;
        if (first_en != s + 1) begin fails++; $display("FAIL basic_first_read: got %0d want %0d", first_en, s + 1); end
        tests++;
        if (first_x != s + 3) begin fails++; $display("FAIL basic_first_word: got %0d want %0d", first_x, s + 3); end
        tests++;
        if (last_x - first_x != 5) begin fails++; $display("FAIL basic_no_bubble: got %0d want 5", last_x - first_x); end
        tests++;
        if (done_cyc != last_x + 1) begin fails++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc, last_x + 1); end
        tests++;
        if (done_cnt - d0 != 1) begin fails++; $display("FAIL basic_done_once: got %0d want 1", done_cnt - d0); end
        tests++;
        if (ctrl3 !== 32'h0006_0002) begin fails++; $display("FAIL basic_status: got %h want 00060002", ctrl3); end
        tests++;
        if (exp_q.size() != 0 || aq.size() != 0) begin
            fails++;
            $display("FAIL basic_leftover: got %0d/%0d want 0/0", exp_q.size(), aq.size());
        end
    endtask

    task automatic test_wrap();
        int s, d0;
        d0 = done_cnt;
        start_job(12'hFFE, 5'b00010, 8'd2, 1'b0, s);
        wait_done(d0);
        tests++;
        if (x_job != 4 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL wrap_count: got %0d left %0d want 4 left 0", x_job, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int s, d0;
        d0 = done_cnt;
        start_job(12'h123, 5'b10000, 8'd1, 1'b0, s);
        chk_occ = 1;
        for (int c = 0; c < 400 && done_cnt == d0; c++) begin
            weight_ready = (c % 4 == 0) || (c % 4 == 3);
            step();
        end
        chk_occ = 0;
        weight_ready = 1;
        tests++;
        if (done_cnt == d0) begin fails++; $display("FAIL stall_timeout: got no done want done pulse"); end
        tests++;
        if (x_job != 5 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL stall_count: got %0d left %0d want 5 left 0", x_job, exp_q.size());
        end
        tests++;
        if (ctrl3[26:16] !== 11'd5) begin fails++; $display("FAIL stall_status: got %0d want 5", ctrl3[26:16]); end
    endtask

    task automatic test_no_weights();
        int s, d0;
        d0 = done_cnt;
        start_job(12'h000, 5'b00100, 8'd1, 1'b1, s);
        wait_done(d0);
        tests++;
        if (en_job != 0 || done_cyc != s + 1) begin
            fails++;
            $display("FAIL pool: got reads=%0d done@%0d want reads=0 done@%0d", en_job, done_cyc, s + 1);
        end
        tests++;
        if (ctrl3[2:0] !== 3'b010) begin fails++; $display("FAIL pool_status: got %b want 010", ctrl3[2:0]); end
        d0 = done_cnt;
        start_job(12'h000, 5'b00110, 8'd1, 1'b0, s);
        wait_done(d0);
        tests++;
        if (en_job != 0 || done_cyc != s + 1) begin
            fails++;
            $display("FAIL badk: got reads=%0d done@%0d want reads=0 done@%0d", en_job, done_cyc, s + 1);
        end
        tests++;
        if (ctrl3[2:0] !== 3'b110) begin fails++; $display("FAIL badk_status: got %b want 110", ctrl3[2:0]); end
    endtask

    task automatic test_abort();
        int s, d0;
        weight_ready = 1;
        start_job(12'h200, 5'b10000, 8'd4, 1'b0, s);
        step(); step(); step();
        tests++;
        if (weight_valid !== 1'b1) begin fails++; $display("FAIL abort_pre_valid: got %0b want 1", weight_valid); end
        ctrl2[6] = 1;
        step();
        tests++;
        if ({weight_valid, done, ctrl3[0]} !== 3'b010) begin
            fails++;
            $display("FAIL abort: got v/d/busy=%b want 010", {weight_valid, done, ctrl3[0]});
        end
        step();
        tests++;
        if ({done, ctrl3[2:0]} !== 4'b0010) begin
            fails++;
            $display("FAIL abort_after: got %b want 0010", {done, ctrl3[2:0]});
        end
        ctrl2[6] = 0;
        exp_q.delete();
        aq.delete();
        d0 = done_cnt;
        start_job(12'h300, 5'b00100, 8'd1, 1'b0, s);
        wait_done(d0);
        tests++;
        if (x_job != 3 || exp_q.size() != 0 || ctrl3[26:16] !== 11'd3) begin
            fails++;
            $display("FAIL abort_restart: got %0d words status %0d want 3 3", x_job, ctrl3[26:16]);
        end
    endtask

    task automatic test_reset_mid_drain();
        int s, d0;
        weight_ready = 0;
        start_job(12'h020, 5'b00010, 8'd1, 1'b0, s);
        step(); step(); step(); step();
        tests++;
        if (ctrl3[0] !== 1'b1 || weight_valid !== 1'b1) begin
            fails++;
            $display("FAIL drain_busy: got busy=%0b v=%0b want 1 1", ctrl3[0], weight_valid);
        end
        rst_n = 0;
        exp_q.delete();
        aq.delete();
        #1;
        tests++;
        if ({en_a, en_b, addr_a, addr_b, weight_valid, done} !== 28'd0 || weight_out !== '0 || ctrl3 !== 32'd0) begin
            fails++;
            $display("FAIL midreset: got %h st=%h want 0", {en_a, en_b, addr_a, addr_b, weight_valid, done}, ctrl3);
        end
        step(); step();
        rst_n = 1;
        en_job = 0;
        for (int c = 0; c < 6; c++) step();
        tests++;
        if (en_job != 0 || ctrl3 !== 32'd0) begin
            fails++;
            $display("FAIL no_restart: got reads=%0d st=%h want 0 0", en_job, ctrl3);
        end
        weight_ready = 1;
        d0 = done_cnt;
        start_job(12'h040, 5'b00001, 8'd3, 1'b0, s);
        wait_done(d0);
        tests++;
        if (x_job != 3 || ctrl3[26:16] !== 11'd3) begin
            fails++;
            $display("FAIL post_reset_job: got %0d status %0d want 3 3", x_job, ctrl3[26:16]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_no_weights();
        test_abort();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
